instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly downstream of the core's instruction memory. Owns the program counter, drives the memory read address, and assembles 1- or 2-byte instructions (opcode plus optional immediate). Presents them to the core control unit over a valid/ready handshake. Applies taken jumps and halts on ENDOP.

## Interface
- DATA_WIDTH, 8, instruction byte width
- ADDR_WIDTH, 8, instruction memory address width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin fetching at address 0 (honoured in IDLE or HALT only)
- mem_busy  in  1  instruction memory write port active (we high); fetch must not issue reads
- r_addr  out  ADDR_WIDTH  read address to instruction memory (registered, equals pc)
- r_instr  in  DATA_WIDTH  registered read data from instruction memory (valid the cycle after r_addr is held with mem_busy low)
- instr_valid  out  1  instruction presented
- instr_ready  in  1  core accepts instruction
- opcode  out  DATA_WIDTH  fetched opcode
- operand  out  DATA_WIDTH  immediate byte; 0 when has_operand=0
- has_operand  out  1  opcode carries an immediate
- jump_en  in  1  with the accepting handshake: redirect pc
- jump_addr  in  ADDR_WIDTH  jump target
- pc  out  ADDR_WIDTH  address of next byte to fetch
- halted  out  1  ENDOP accepted; fetch stopped

## Operation
- States: IDLE, F_OP, L_OP, F_IMM, L_IMM, PRESENT, HALT.
- IDLE: on start, pc←0 and go to F_OP.
- F_OP: r_addr=pc. If mem_busy, stay. Otherwise go to L_OP.
- L_OP: opcode←r_instr; pc←pc+1.
  - If the opcode is LDACI (0), STACI (13) or JPNZ (27), go to F_IMM.
  - Otherwise operand←0, has_operand←0, and go to PRESENT.
- F_IMM: same as F_OP, including the mem_busy stall. Go to L_IMM.
- L_IMM: operand←r_instr; has_operand←1; pc←pc+1; go to PRESENT.
- PRESENT: instr_valid=1. opcode, operand and has_operand are held stable until accepted.
  - On instr_valid && instr_ready:
    - If opcode==ENDOP (28), go to HALT.
    - Else if jump_en, pc←jump_addr and go to F_OP.
    - Else go to F_OP.
- HALT: halted=1, instr_valid=0. start restarts: pc←0, halted←0, go to F_OP.
- Handshake rules:
  - jump_en is ignored unless the handshake completes that cycle.
  - jump_en is ignored on ENDOP.
  - start is ignored outside IDLE and HALT.
- Unknown opcodes (>47) are presented as single-byte instructions; decode is the core's responsibility.
- pc arithmetic is modulo 2^ADDR_WIDTH: 255+1→0. An immediate at address 0 after an opcode at 255 is legal.
- mem_busy is sampled only in F_OP and F_IMM. The memory does not update its read register while being written, so L_OP and L_IMM are reached only after a non-busy F cycle.

## Timing
- Reset (async): state IDLE; pc, r_addr, opcode, operand = 0; instr_valid, has_operand, halted = 0.
- Reset mid-instruction discards any partial opcode or operand.
- Memory read latency is 1 cycle: address is held in F_*, data is sampled in L_*.
- Latency with instr_ready high and no stalls, counted from the start edge to instr_valid high:
  - single-byte instruction: 3 cycles
  - two-byte instruction: 5 cycles
- Throughput:
  - 3 cycles per single-byte instruction (accept → F_OP → L_OP → PRESENT)
  - 5 cycles per two-byte instruction
- Each mem_busy cycle in F_OP or F_IMM adds exactly 1 cycle.
- instr_valid stays high indefinitely while instr_ready is low; outputs do not change.
- Jump target is fetched in the F_OP cycle immediately after acceptance: r_addr=jump_addr one cycle after the handshake edge.

## Test plan
- Memory holds CLRAC(24), LDACI(0), 9, INAC(26), ENDOP(28); start with ready high.
  - Expect the sequence {24,-}, {0,9}, {26,-}, {28,-}.
  - First valid 3 cycles after start; halted=1 after ENDOP is accepted; pc=5.
- Backpressure: hold instr_ready low for 4 cycles on LDACI 9.
  - instr_valid, opcode=0 and operand=9 stay stable throughout.
  - pc does not advance; exactly one acceptance occurs.
- Jump: JPNZ(27), 7 at addresses 101–102; accept with jump_en=1 and jump_addr=7.
  - Next r_addr=7; the opcode fetched is mem[7].
  - With jump_en=0 instead, the next fetch is address 103.
- mem_busy asserted 3 cycles during F_IMM of STACI 52.
  - Operand=52 is captured only after busy drops.
  - Latency is 8 cycles; no spurious valid.
- Wrap and reset:
  - Opcode LDACI at 255 with immediate 0x11 at 0: presented operand=0x11, pc=1.
  - Assert rst in L_IMM: all outputs are 0 immediately and the state is IDLE.
  - start afterwards refetches from address 0.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage sitting directly after the instruction memory.
// Owns the program counter, drives the memory read address, and assembles
// 1- or 2-byte instructions (opcode plus optional immediate byte). Completed
// instructions are offered to the control unit over a valid/ready handshake.
// Taken jumps are applied on the accepting handshake; ENDOP halts fetching.
//
// Ports
//   clk          single clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   start        pulse: begin fetching at address 0 (only from IDLE or HALT)
//   mem_busy     instruction memory write port active; no reads may issue
//   r_addr       read address to instruction memory (always equals pc)
//   r_instr      registered read data from instruction memory
//   instr_valid  instruction presented to the core
//   instr_ready  core accepts the presented instruction
//   opcode       fetched opcode
//   operand      immediate byte, 0 for single-byte instructions
//   has_operand  opcode carries an immediate
//   jump_en      with the accepting handshake: redirect pc to jump_addr
//   jump_addr    jump target
//   pc           address of the next byte to fetch
//   halted       ENDOP accepted, fetch stopped
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mem_busy,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  has_operand,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  // Opcodes the fetch stage has to recognise itself.
  localparam logic [DATA_WIDTH-1:0] OP_LDACI = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] OP_STACI = DATA_WIDTH'(13);
  localparam logic [DATA_WIDTH-1:0] OP_JPNZ  = DATA_WIDTH'(27);
  localparam logic [DATA_WIDTH-1:0] OP_ENDOP = DATA_WIDTH'(28);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    F_OP,
    L_OP,
    F_IMM,
    L_IMM,
    PRESENT,
    HALT
  } state_t;

  state_t state_reg;

  // Only these three opcodes are followed by an immediate byte. Anything
  // else, including undefined opcodes, is treated as a single byte.
  function automatic logic needs_imm(input logic [DATA_WIDTH-1:0] op);
    return (op == OP_LDACI) || (op == OP_STACI) || (op == OP_JPNZ);
  endfunction

  // The read address is the pc register itself, so the memory sees the
  // jump target in the very cycle after the accepting handshake.
  assign r_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc          <= '0;
      opcode      <= '0;
      operand     <= '0;
      has_operand <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pc        <= '0;
            state_reg <= F_OP;
          end
        end

        // Address is already on r_addr; a busy cycle means the memory read
        // register is frozen, so wait for a clean read before loading.
        F_OP: begin
          if (!mem_busy) begin
            state_reg <= L_OP;
          end
        end

        L_OP: begin
          opcode <= r_instr;
          pc     <= pc + PC_ONE;
          if (needs_imm(r_instr)) begin
            state_reg <= F_IMM;
          end else begin
            operand     <= '0;
            has_operand <= 1'b0;
            instr_valid <= 1'b1;
            state_reg   <= PRESENT;
          end
        end

        F_IMM: begin
          if (!mem_busy) begin
            state_reg <= L_IMM;
          end
        end

        L_IMM: begin
          operand     <= r_instr;
          has_operand <= 1'b1;
          pc          <= pc + PC_ONE;
          instr_valid <= 1'b1;
          state_reg   <= PRESENT;
        end

        // Outputs are frozen until the core takes the instruction. The
        // jump request only matters on the accepting edge, and never for
        // ENDOP.
        PRESENT: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (opcode == OP_ENDOP) begin
              halted    <= 1'b1;
              state_reg <= HALT;
            end else if (jump_en) begin
              pc        <= jump_addr;
              state_reg <= F_OP;
            end else begin
              state_reg <= F_OP;
            end
          end
        end

        HALT: begin
          if (start) begin
            pc        <= '0;
            halted    <= 1'b0;
            state_reg <= F_OP;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. A behavioural instruction memory with a registered
// read port (frozen while mem_busy is high) feeds the DUT. Expected
// instructions are pushed to a scoreboard queue when a program is started and
// popped on every accepting handshake. A table of single-instruction programs
// covers decode and latency; hand-written sequences cover backpressure,
// jumps, memory stalls, pc wrap and reset mid-instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_busy;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] opcode;
  logic [DW-1:0] operand;
  logic          has_operand;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic [AW-1:0] pc;
  logic          halted;

  logic [DW-1:0] mem [0:255];

  int errors  = 0;
  int checks  = 0;
  int accepts = 0;

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] opd;
    logic       has;
  } instr_t;

  instr_t exp_q[$];

  typedef struct {
    logic [7:0] op;
    logic [7:0] imm;
    logic [7:0] e_opd;
    logic       e_has;
    int         e_lat;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  instr_fetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_busy   (mem_busy),
    .r_addr     (r_addr),
    .r_instr    (r_instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode     (opcode),
    .operand    (operand),
    .has_operand(has_operand),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .pc         (pc),
    .halted     (halted)
  );

  // Instruction memory: registered read, read register frozen while busy.
  always @(posedge clk) begin
    if (!mem_busy) r_instr <= mem[r_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: one line per accepted instruction.
  always @(negedge clk) begin
    if (rst === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      instr_t e;
      accepts++;
      $display("accept opcode=%0d operand=%0d has_operand=%0b pc=%0d",
               opcode, operand, has_operand, pc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got opcode %0d, required no instruction", opcode);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", 32'({opcode, operand, has_operand}), 32'({e.opc, e.opd, e.has}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic push(input logic [7:0] opc, input logic [7:0] opd, input logic has);
    instr_t e;
    e.opc = opc;
    e.opd = opd;
    e.has = has;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts negedges until instr_valid is seen; a missing valid is a failure.
  task automatic wait_valid(input string name, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (instr_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_valid_timeout: got no instr_valid, required valid within 40 cycles", name);
    end
  endtask

  task automatic wait_halt(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (halted === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_halt_timeout: got halted=%0b, required 1 within 60 cycles", name, halted);
    end
    tick();
  endtask

  // Waits for a presented instruction, then accepts it in a single cycle
  // with the given jump request. Returns at handshake edge + 1.
  task automatic accept_with(input string name, input logic je, input logic [7:0] ja);
    int n;
    wait_valid(name, n);
    tick();
    instr_ready = 1'b1;
    jump_en     = je;
    jump_addr   = ja;
    tick();
    instr_ready = 1'b0;
    jump_en     = 1'b0;
  endtask

  initial begin
    int n;
    int acc0;

    rst         = 1'b1;
    start       = 1'b0;
    mem_busy    = 1'b0;
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = '0;
    clear_mem();

    vecs[0] = '{8'd24,  8'h55, 8'h00, 1'b0, 3, 8'd2};  // CLRAC
    vecs[1] = '{8'd0,   8'h09, 8'h09, 1'b1, 5, 8'd3};  // LDACI 9
    vecs[2] = '{8'd13,  8'd52, 8'd52, 1'b1, 5, 8'd3};  // STACI 52
    vecs[3] = '{8'd27,  8'hA7, 8'hA7, 1'b1, 5, 8'd3};  // JPNZ, not taken
    vecs[4] = '{8'd48,  8'h33, 8'h00, 1'b0, 3, 8'd2};  // first undefined opcode
    vecs[5] = '{8'hFF,  8'h44, 8'h00, 1'b0, 3, 8'd2};  // undefined, max value
    vecs[6] = '{8'd26,  8'h66, 8'h00, 1'b0, 3, 8'd2};  // INAC
    vecs[7] = '{8'd28,  8'h77, 8'h00, 1'b0, 3, 8'd1};  // ENDOP alone

    // ---------------- reset state ----------------
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_pc",     32'(pc),     32'd0);
    check("reset_r_addr", 32'(r_addr), 32'd0);
    check("reset_opcode", 32'(opcode), 32'd0);
    check("reset_operand", 32'(operand), 32'd0);
    check("reset_flags", 32'({instr_valid, has_operand, halted}), 32'd0);

    // ---------------- program: CLRAC, LDACI 9, INAC, ENDOP ----------------
    mem[0] = 8'd24; mem[1] = 8'd0; mem[2] = 8'd9; mem[3] = 8'd26; mem[4] = 8'd28;
    push(8'd24, 8'd0, 1'b0);
    push(8'd0,  8'd9, 1'b1);
    push(8'd26, 8'd0, 1'b0);
    push(8'd28, 8'd0, 1'b0);
    instr_ready = 1'b1;
    pulse_start();
    wait_valid("prog", n);
    check("prog_latency", 32'(n), 32'd3);
    wait_halt("prog");
    check("prog_halted", 32'(halted), 32'd1);
    check("prog_pc", 32'(pc), 32'd5);
    check("prog_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- table: one instruction then ENDOP ----------------
    for (int v = 0; v < 8; v++) begin
      clear_mem();
      mem[0] = vecs[v].op;
      if (vecs[v].e_has) begin
        mem[1] = vecs[v].imm;
        mem[2] = 8'd28;
      end else begin
        mem[1] = 8'd28;
      end
      push(vecs[v].op, vecs[v].e_opd, vecs[v].e_has);
      if (vecs[v].op != 8'd28) push(8'd28, 8'd0, 1'b0);
      instr_ready = 1'b1;
      pulse_start();
      check("vec_restart_halted", 32'(halted), 32'd0);
      check("vec_restart_addr", 32'(r_addr), 32'd0);
      wait_valid("vec", n);
      check("vec_latency", 32'(n), 32'(vecs[v].e_lat));
      wait_halt("vec");
      check("vec_pc", 32'(pc), 32'(vecs[v].e_pc));
    end
    check("vec_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- backpressure on LDACI 9 ----------------
    clear_mem();
    mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd28;
    push(8'd0,  8'd9, 1'b1);
    push(8'd28, 8'd0, 1'b0);
    instr_ready = 1'b0;
    pulse_start();
    wait_valid("bp", n);
    acc0 = accepts;
    for (int k = 0; k < 4; k++) begin
      check("bp_hold", 32'({instr_valid, opcode, operand, has_operand, pc}),
            32'({1'b1, 8'd0, 8'd9, 1'b1, 8'd2}));
      @(negedge clk);
    end
    check("bp_no_accept", 32'(accepts - acc0), 32'd0);
    tick();
    instr_ready = 1'b1;
    wait_halt("bp");
    check("bp_accepts", 32'(accepts - acc0), 32'd2);

    // ---------------- jump taken: 101 -> JPNZ 7 -> 7 ----------------
    clear_mem();
    mem[0]   = 8'd24;  mem[1]   = 8'd28;
    mem[101] = 8'd27;  mem[102] = 8'd7;
    mem[7]   = 8'd26;  mem[8]   = 8'd28;
    mem[103] = 8'd24;  mem[104] = 8'd28;
    push(8'd24, 8'd0, 1'b0);
    push(8'd27, 8'd7, 1'b1);
    push(8'd26, 8'd0, 1'b0);
    push(8'd28, 8'd0, 1'b0);
    instr_ready = 1'b0;
    pulse_start();
    wait_valid("jA", n);
    tick();
    jump_en   = 1'b1;          // no handshake: must not move pc
    jump_addr = 8'd200;
    tick();
    jump_en   = 1'b0;
    check("jmp_no_handshake", 32'({instr_valid, pc}), 32'({1'b1, 8'd1}));
    accept_with("jA_to101", 1'b1, 8'd101);
    check("jA_addr101", 32'(r_addr), 32'd101);
    accept_with("jA_to7", 1'b1, 8'd7);
    check("jA_addr7", 32'(r_addr), 32'd7);
    instr_ready = 1'b1;
    wait_halt("jA");
    check("jA_pc", 32'(pc), 32'd9);

    // ---------------- same JPNZ, not taken; jump on ENDOP ignored ----------------
    push(8'd24, 8'd0, 1'b0);
    push(8'd27, 8'd7, 1'b1);
    push(8'd24, 8'd0, 1'b0);
    push(8'd28, 8'd0, 1'b0);
    instr_ready = 1'b0;
    pulse_start();
    accept_with("jB_to101", 1'b1, 8'd101);
    accept_with("jB_fall", 1'b0, 8'd7);
    check("jB_addr103", 32'(r_addr), 32'd103);
    accept_with("jB_clrac", 1'b0, 8'd0);
    accept_with("jB_endop", 1'b1, 8'd50);
    check("jB_endop_halt", 32'({halted, pc}), 32'({1'b1, 8'd105}));
    check("jump_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- mem_busy for 3 cycles during F_IMM of STACI 52 ----------------
    clear_mem();
    mem[0] = 8'd13; mem[1] = 8'd52; mem[2] = 8'd28;
    push(8'd13, 8'd52, 1'b1);
    push(8'd28, 8'd0,  1'b0);
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;                     // edges seen since the start edge
    for (int k = 0; k < 20 && instr_valid !== 1'b1; k++) begin
      if (n == 3) mem_busy = 1'b1;   // F_IMM begins after the third edge
      if (n == 6) mem_busy = 1'b0;
      tick();
      n++;
    end
    mem_busy = 1'b0;
    check("busy_latency", 32'(n), 32'd8);
    wait_halt("busy");
    check("busy_pc", 32'(pc), 32'd3);

    // ---------------- wrap: LDACI at 255, immediate 0x11 at 0 ----------------
    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'd28; mem[255] = 8'd0;
    push(8'h11, 8'd0,  1'b0);
    push(8'd0,  8'h11, 1'b1);
    push(8'd28, 8'd0,  1'b0);
    instr_ready = 1'b0;
    pulse_start();
    accept_with("wrap_jump", 1'b1, 8'd255);
    check("wrap_addr255", 32'(r_addr), 32'd255);
    wait_valid("wrap", n);
    check("wrap_present", 32'({opcode, operand, has_operand, pc}),
          32'({8'd0, 8'h11, 1'b1, 8'd1}));
    tick();
    instr_ready = 1'b1;
    wait_halt("wrap");
    check("wrap_pc", 32'(pc), 32'd2);

    // ---------------- reset asserted in L_IMM of STACI at 255 ----------------
    mem[255] = 8'd13;
    push(8'h11, 8'd0, 1'b0);
    instr_ready = 1'b0;
    pulse_start();
    accept_with("rst_jump", 1'b1, 8'd255);   // now in F_OP
    tick();                                   // L_OP
    tick();                                   // F_IMM
    tick();                                   // L_IMM
    rst = 1'b1;
    #1;
    check("rst_async_outputs",
          32'({pc, r_addr, opcode}), 32'd0);
    check("rst_async_flags",
          32'({operand, instr_valid, has_operand, halted}), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    check("rst_idle", 32'({instr_valid, halted, pc}), 32'd0);
    push(8'h11, 8'd0, 1'b0);
    push(8'd28, 8'd0, 1'b0);
    pulse_start();
    check("rst_refetch_addr", 32'(r_addr), 32'd0);
    wait_valid("rst_refetch", n);
    check("rst_refetch_latency", 32'(n), 32'd3);
    wait_halt("rst_refetch");
    check("rst_refetch_pc", 32'(pc), 32'd2);

    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
